// File: rtl/word_storage_reader.sv
// Streams a full word buffer out byte by byte, then releases it; first byte 2 cycles after full is sampled in IDLE.
// Valid/ready output: the byte register holds while dout_valid && !rd_en, refilled only when free or being consumed.
module word_storage_reader #(
  parameter  int WORD_MAX_LEN = 32,
  parameter  int CNT_WIDTH    = 16,
  localparam int LEN_W        = $clog2(WORD_MAX_LEN + 1),
  localparam int ADDR_W       = (WORD_MAX_LEN > 1) ? $clog2(WORD_MAX_LEN) : 1
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 full,
  input  logic [LEN_W-1:0]     word_len,
  input  logic [7:0]           st_dout,
  output logic [ADDR_W-1:0]    rd_addr,
  output logic                 set_empty,
  output logic [7:0]           dout,
  output logic                 dout_valid,
  output logic                 dout_last,
  input  logic                 rd_en,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic                 idle
);

  typedef enum logic [1:0] {IDLE, SEND, RELEASE, WAIT_CLR} state_t;

  state_t           state;
  state_t           next_state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_in;
  logic             load;
  logic             load_last;

  assign len_in    = (word_len > LEN_W'(WORD_MAX_LEN)) ? LEN_W'(WORD_MAX_LEN) : word_len;
  assign load      = (state == SEND) && (!dout_valid || rd_en);
  assign load_last = load && (LEN_W'(rd_addr) == len_q - LEN_W'(1));

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (full) next_state = (len_in == '0) ? RELEASE : SEND;
      SEND:     if (load_last) next_state = RELEASE;
      RELEASE:  next_state = WAIT_CLR;
      WAIT_CLR: if (!full) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    set_empty = (state == RELEASE);
    idle      = (state == IDLE) && !dout_valid;
  end

  // Datapath: read address, output byte register and delivered-word counter.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      len_q      <= '0;
      rd_addr    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      word_count <= '0;
    end else begin
      if (state == IDLE && full) begin
        len_q   <= len_in;
        rd_addr <= '0;
      end
      if (load) begin
        dout       <= st_dout;
        dout_valid <= 1'b1;
        dout_last  <= load_last;
        // Parking at 0 after the final byte keeps rd_addr inside the buffer.
        rd_addr    <= load_last ? '0 : rd_addr + ADDR_W'(1);
      end else if (rd_en) begin
        dout_valid <= 1'b0;
      end
      if (state == RELEASE) begin
        word_count <= word_count + CNT_WIDTH'(1);
        rd_addr    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_word_storage_reader.sv
// Randomized bench for word_storage_reader: a byte-queue scoreboard models the buffer contents
// expected on the output, plus per-word beat/release/counter and handshake stability checks.
module tb_word_storage_reader;

  logic        CLK = 1'b0;
  logic        reset;
  logic        full;
  logic [5:0]  word_len;
  logic [7:0]  st_dout;
  logic [4:0]  rd_addr;
  logic        set_empty;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_last;
  logic        rd_en;
  logic [15:0] word_count;
  logic        idle;

  word_storage_reader #(.WORD_MAX_LEN(32), .CNT_WIDTH(16)) dut (
    .CLK(CLK), .reset(reset), .full(full), .word_len(word_len), .st_dout(st_dout),
    .rd_addr(rd_addr), .set_empty(set_empty), .dout(dout), .dout_valid(dout_valid),
    .dout_last(dout_last), .rd_en(rd_en), .word_count(word_count), .idle(idle)
  );

  always #5 CLK = ~CLK;

  logic [7:0] mem [32];
  assign st_dout = mem[rd_addr];

  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [8:0] expq[$];
  int         beats, se_cnt, max_addr, addr_err, model_cnt, stall_left, start_cyc, rd_pct;
  bit         first_seen, stall_req, stall_done, prev_vld, prev_rdy;
  logic [8:0] prev_beat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic fill_exp(input int n);
    expq.delete();
    for (int i = 0; i < n; i++) expq.push_back({(i == n - 1), mem[i]});
  endtask

  task automatic monitor();
    logic [8:0] e;
    if (int'(rd_addr) > 31) addr_err++;
    if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
    if (prev_vld && !prev_rdy) begin
      chk("hold_vld", dout_valid, 1);
      chk("hold_dat", {dout_last, dout}, prev_beat);
    end
    if (dout_valid && !first_seen) begin
      first_seen = 1;
      chk("latency", cyc - start_cyc, 2);
    end
    if (set_empty) se_cnt++;
    if (dout_valid && rd_en) begin
      beats++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("beat", {dout_last, dout}, e);
      end
    end
    prev_vld  = dout_valid;
    prev_rdy  = rd_en;
    prev_beat = {dout_last, dout};
  endtask

  // One clock: drive this cycle's rd_en and buffer full flag at the negedge, then observe.
  task automatic cycle();
    @(negedge CLK);
    cyc++;
    if (stall_req && dout_valid && !stall_done) begin
      stall_left = 4;
      stall_done = 1;
    end
    if (stall_left > 0) begin
      rd_en = 1'b0;
      stall_left--;
    end else begin
      rd_en = ($urandom_range(99) < rd_pct);
    end
    if (set_empty) full = 1'b0;
    monitor();
  endtask

  task automatic run_word(input int len, input bit stall, input int rst_after);
    int n;
    bit done, rst_done;
    n = (len > 32) ? 32 : len;
    fill_exp(n);
    beats = 0; se_cnt = 0; first_seen = 0;
    stall_req = stall; stall_done = 0;
    word_len = 6'(len);
    full = 1'b1;
    start_cyc = cyc;
    done = 0; rst_done = 0;
    for (int k = 0; k < 1000 && !done; k++) begin
      if (rst_after > 0 && !rst_done && beats == rst_after) begin
        @(negedge CLK);
        cyc++;
        reset = 1'b1;
        #1;
        chk("rst_vld", dout_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_last", dout_last, 0);
        chk("rst_se", set_empty, 0);
        chk("rst_wc", word_count, 0);
        @(negedge CLK);
        cyc++;
        reset = 1'b0;
        start_cyc = cyc;
        fill_exp(n);
        beats = 0; se_cnt = 0; first_seen = 0; prev_vld = 0;
        model_cnt = 0;
        rst_done = 1;
      end
      cycle();
      done = !full && idle && (expq.size() == 0);
    end
    chk("done", done, 1);
    model_cnt++;
    chk("beats", beats, n);
    chk("set_empty_pulses", se_cnt, 1);
    chk("word_count", word_count, 32'(model_cnt & 16'hffff));
  endtask

  initial begin
    reset = 1'b1; full = 1'b0; rd_en = 1'b0; word_len = '0;
    rd_pct = 100; stall_left = 0; stall_req = 0; prev_vld = 0;
    max_addr = 0; addr_err = 0; model_cnt = 0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    repeat (2) @(negedge CLK);
    chk("reset_vld", dout_valid, 0);
    chk("reset_dout", dout, 0);
    chk("reset_last", dout_last, 0);
    chk("reset_se", set_empty, 0);
    chk("reset_wc", word_count, 0);
    chk("reset_idle", idle, 1);
    chk("reset_addr", rd_addr, 0);
    reset = 1'b0;

    mem[0] = 8'h61; mem[1] = 8'h62; mem[2] = 8'h63;
    run_word(3, 0, 0);
    run_word(3, 1, 0);

    mem[0] = 8'h01; mem[1] = 8'h02;
    run_word(2, 0, 0);
    mem[0] = 8'h10;
    run_word(1, 0, 0);

    run_word(0, 0, 0);
    chk("zero_len_idle", idle, 1);

    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    max_addr = 0;
    run_word(40, 0, 0);
    chk("max_addr", max_addr, 31);

    for (int i = 0; i < 5; i++) mem[i] = 8'hA0 + 8'(i);
    run_word(5, 0, 2);
    chk("wc_after_reset", word_count, 1);

    for (int w = 0; w < 20; w++) begin
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
      rd_pct = $urandom_range(100, 30);
      run_word($urandom_range(40, 0), 0, 0);
    end
    rd_pct = 100;

    chk("addr_range", addr_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
